// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial line and the received-byte outputs of uart_rx.
// Ports: rx (serial line, idle high), data_out[7:0], data_valid, frame_error, busy.
// master = line/consumer side (drives rx), slave = receiver side (drives results).
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  rx,
        output data_out,
        output data_valid,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, glitch rejection and break hold-off.
// Latency: byte delivered 2 + H + 9*N cycles after the start edge reaches the first sync flop.
// Ports: clk, reset (sync, active-high), bus (uart_rx_if.slave: rx in; data_out/data_valid/frame_error/busy out).
module uart_rx #(
    parameter int CLKS_PER_BIT = 650
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_error_q, frame_error_d;

    // State register, synchroniser and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_meta_q     <= bus.rx;
            rx_s_q        <= rx_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // Line back high at mid start bit: treat as a glitch
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL_M1) begin
                    cnt_d = '0;
                    // Returning at mid stop bit leaves half a bit to catch the next start edge
                    state_d = rx_s_q ? S_IDLE : S_BREAK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                // Hold off until the line releases so a held-low line is not read as 0x00 frames
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        if (state_q == S_STOP && cnt_q == CNT_FULL_M1) begin
            if (rx_s_q) begin
                data_valid_d = 1'b1;
                data_out_d   = shift_q;
            end else begin
                frame_error_d = 1'b1;
            end
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into uart_rx (N=16 and default N=650) and checks against a frame-level model.
// Ports: none (top-level bench); instantiates two uart_rx_if interfaces and two uart_rx instances.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_uart_rx;
    localparam int N    = 16;
    localparam int H    = N / 2;
    localparam int NB   = 650;
    localparam int HB   = NB / 2;
    localparam int MAXC = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16;
    logic rst650;

    uart_rx_if if16();
    uart_rx_if if650();

    uart_rx #(.CLKS_PER_BIT(N)) dut16 (
        .clk   (clk),
        .reset (rst16),
        .bus   (if16)
    );

    uart_rx dut650 (
        .clk   (clk),
        .reset (rst650),
        .bus   (if650)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Rising-edge index; read on falling edges
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed history and events
    bit         busy_hist [0:MAXC-1];
    int         both_hi = 0;
    int         ev_cyc [$];
    bit         ev_err [$];
    logic [7:0] ev_dat [$];
    int         ev650_cyc [$];
    logic [7:0] ev650_dat [$];

    always @(negedge clk) begin
        if (cyc < MAXC) busy_hist[cyc] <= if16.busy;
        if (if16.data_valid && if16.frame_error) both_hi <= both_hi + 1;
        if (if16.data_valid || if16.frame_error) begin
            ev_cyc.push_back(cyc);
            ev_err.push_back(if16.frame_error);
            ev_dat.push_back(if16.data_out);
        end
        if (if650.data_valid) begin
            ev650_cyc.push_back(cyc);
            ev650_dat.push_back(if650.data_out);
        end
    end

    // Reference model: expected events derived from each whole frame sent
    int         exp_cyc [$];
    bit         exp_err [$];
    logic [7:0] exp_dat [$];
    logic [7:0] last_good = 8'h00;

    function automatic bit hist(input int c);
        if (c >= 0 && c < MAXC) return busy_hist[c];
        return 1'b0;
    endfunction

    // Called just after a falling edge; returns the edge index T0 at which the start bit is first captured
    task automatic send16(input logic [7:0] b, input bit stop, output int t0);
        if16.rx = 1'b0;
        t0 = cyc + 1;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if16.rx = b[i];
            repeat (N) @(negedge clk);
        end
        if16.rx = stop;
        repeat (N) @(negedge clk);
        exp_cyc.push_back(t0 + 2 + H + 9 * N);
        exp_err.push_back(!stop);
        if (stop) begin
            exp_dat.push_back(b);
            last_good = b;
        end else begin
            exp_dat.push_back(last_good);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, ev_cyc.size(), exp_cyc.size());
        while (ev_cyc.size() > 0 && exp_cyc.size() > 0) begin
            check({tag, "_time"}, ev_cyc.pop_front(), exp_cyc.pop_front());
            check({tag, "_kind"}, 32'(ev_err.pop_front()), 32'(exp_err.pop_front()));
            check({tag, "_data"}, ev_dat.pop_front(), exp_dat.pop_front());
        end
        ev_cyc.delete();  ev_err.delete();  ev_dat.delete();
        exp_cyc.delete(); exp_err.delete(); exp_dat.delete();
        check({tag, "_dout"}, if16.data_out, last_good);
    endtask

    initial begin
        int t0;
        int ta;
        int c;
        logic [7:0] b;
        bit stop;

        if16.rx  = 1'b1;
        if650.rx = 1'b1;
        rst16    = 1'b1;
        rst650   = 1'b1;
        @(negedge clk);
        if16.rx = 1'b0;           // line activity during reset must be ignored
        @(negedge clk);
        if16.rx = 1'b1;
        @(negedge clk);
        check("rst_busy",  if16.busy, 0);
        check("rst_dout",  if16.data_out, 8'h00);
        check("rst_valid", if16.data_valid, 0);
        check("rst_ferr",  if16.frame_error, 0);
        rst16  = 1'b0;
        rst650 = 1'b0;
        idle(4);

        // Single good frame: timing of busy and the valid pulse
        send16(8'hA5, 1'b1, t0);
        check("a5_busy_pre",   hist(t0 + 1), 0);
        check("a5_busy_first", hist(t0 + 2), 1);
        check("a5_busy_last",  hist(t0 + 2 + H + 9 * N - 1), 1);
        check("a5_busy_done",  hist(t0 + 2 + H + 9 * N), 0);
        compare_events("a5");

        // Short low glitch
        idle(5);
        if16.rx = 1'b0;
        t0 = cyc + 1;
        idle(4);
        if16.rx = 1'b1;
        idle(30);
        check("gl_busy_pre",   hist(t0 + 1), 0);
        check("gl_busy_first", hist(t0 + 2), 1);
        check("gl_busy_last",  hist(t0 + 1 + H), 1);
        check("gl_busy_drop",  hist(t0 + 2 + H), 0);
        compare_events("glitch");

        // Good frame, bad stop held low, then recovery
        send16(8'h11, 1'b1, t0);
        idle(3);
        send16(8'h3C, 1'b0, t0);
        idle(40);
        c = cyc;
        if16.rx = 1'b1;
        idle(N);
        check("brk_busy_held", hist(c), 1);
        check("brk_busy_sync", hist(c + 2), 1);
        check("brk_busy_rel",  hist(c + 3), 0);
        send16(8'h0F, 1'b1, t0);
        idle(2);
        compare_events("ferr");

        // Back-to-back frames at full line rate
        idle(5);
        send16(8'h00, 1'b1, ta);
        send16(8'hFF, 1'b1, t0);
        idle(2);
        if (ev_cyc.size() == 2) check("b2b_gap", ev_cyc[1] - ev_cyc[0], 10 * N);
        compare_events("b2b");

        // Reset during data bit 4 of 0x77
        idle(5);
        b = 8'h77;
        if16.rx = 1'b0;
        idle(N);
        for (int i = 0; i < 4; i++) begin
            if16.rx = b[i];
            idle(N);
        end
        if16.rx = b[4];
        idle(N / 2);
        rst16 = 1'b1;
        @(negedge clk);
        check("mrst_busy",  if16.busy, 0);
        check("mrst_dout",  if16.data_out, 8'h00);
        check("mrst_valid", if16.data_valid, 0);
        check("mrst_ferr",  if16.frame_error, 0);
        rst16 = 1'b0;
        if16.rx = 1'b1;
        last_good = 8'h00;
        idle(20);
        send16(8'h81, 1'b1, t0);
        idle(2);
        compare_events("mrst");

        // Randomised frames, gaps and framing errors
        for (int k = 0; k < 25; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send16(b, stop, t0);
            if (!stop) begin
                idle($urandom_range(0, 30));
                if16.rx = 1'b1;
                idle(N);
            end else if ($urandom_range(0, 2) != 0) begin
                idle($urandom_range(1, 2 * N));
            end
        end
        idle(2);
        compare_events("rand");
        check("never_both", both_hi, 0);

        // Default bit period
        idle(5);
        b = 8'h55;
        if650.rx = 1'b0;
        t0 = cyc + 1;
        idle(NB);
        for (int i = 0; i < 8; i++) begin
            if650.rx = b[i];
            idle(NB);
        end
        if650.rx = 1'b1;
        idle(NB);
        check("n650_count", ev650_cyc.size(), 1);
        if (ev650_cyc.size() > 0) begin
            check("n650_time", ev650_cyc[0], t0 + 2 + HB + 9 * NB);
            check("n650_data", ev650_dat[0], 8'h55);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: the receive-side counterpart to the transmit path clocked by `clock_divider`. Samples the asynchronous `rx` line with its own bit-period counter and deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop). Delivers each byte as a one-cycle `data_valid` pulse and flags bad stop bits with `frame_error`. Sits between the board RX pin and the byte-consumer logic.

## Interface
- `CLKS_PER_BIT`, 650: `clk` cycles per bit period (N); must be >= 4.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous serial line, idle high.
- `data_out`  output  8  last correctly received byte.
- `data_valid`  output  1  one-cycle pulse: new byte on `data_out`.
- `frame_error`  output  1  one-cycle pulse: stop bit sampled low.
- `busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- Two-flop synchroniser on `rx`; both flops reset to 1. The FSM uses only the synchronised value `rx_s`.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. H = CLKS_PER_BIT/2 (integer division).
- Bit index is 3 bits, 0..7.
- States:
  - IDLE: counter = 0. If `rx_s` == 0, go to START.
  - START: count up. At count H-1, sample `rx_s`:
    - 0: go to DATA, counter = 0, index = 0.
    - 1: glitch; return to IDLE with no outputs.
  - DATA: count up. At count N-1, sample `rx_s` into shift register bit [index] (LSB first) and reset counter. After index 7, go to STOP.
  - STOP: count up. At count N-1, sample `rx_s`:
    - 1: load `data_out` from the shift register, pulse `data_valid`, go to IDLE.
    - 0: pulse `frame_error`, leave `data_out` unchanged, go to BREAK.
  - BREAK: wait for `rx_s` == 1, then go to IDLE. Prevents a held-low line from being read as a stream of 0x00 frames.
- Samples are taken at mid-bit. The stop bit is sampled at its midpoint, so the FSM is back in IDLE half a bit early and can catch a back-to-back start edge.
- `data_valid` and `frame_error` are never high in the same cycle.
- Reset, including mid-frame: state goes to IDLE; `data_out` = 0x00; `data_valid`, `frame_error`, `busy` = 0; shift register, counter and index = 0. A partial frame is discarded silently.
- `rx` changes during reset are ignored; the first start edge after reset deasserts is received normally.

## Timing
- T0 = the rising edge at which the first synchroniser flop captures `rx` = 0.
- FSM enters START at edge T0+2; `busy` is high from T0+2 onward.
- Start bit validated at T0+2+H.
- Data bit i sampled at T0+2+H+(i+1)·N.
- Stop bit sampled at T0+2+H+9N. Registered outputs `data_out`, `data_valid`/`frame_error` and `busy` = 0 all take effect on that same edge. Pulse width is exactly 1 cycle.
- Tolerance: mid-bit sampling accepts baud mismatch up to roughly ±4% over a frame.
- Minimum frame spacing: next start edge may arrive immediately after the stop bit's nominal end. No frame is dropped at full line rate.
- Glitch rejection: a low pulse shorter than H cycles (after synchronisation) produces no output. `busy` drops at T0+2+H.

## Test plan
- N=16, send 0xA5 with valid stop -> exactly one `data_valid` at edge T0+154, `data_out` = 0xA5, `frame_error` never high, `busy` high T0+2..T0+153.
- N=16, `rx` low for 4 cycles then high -> no `data_valid`/`frame_error`; `busy` high only T0+2..T0+9; `data_out` unchanged.
- N=16, receive 0x11, then send 0x3C with stop bit 0 and hold `rx` low 40 cycles -> one `frame_error` pulse, `data_out` stays 0x11, `busy` stays high until `rx` returns high. A following 0x0F frame is received correctly.
- N=16, back-to-back 0x00 then 0xFF (one stop bit each, no gap) -> two `data_valid` pulses exactly 160 cycles apart, `data_out` 0x00 then 0xFF.
- N=16, assert `reset` for 1 cycle during data bit 4 of 0x77 -> next edge: `busy`=0, `data_out`=0x00, no pulses. Line held high 20 cycles, then 0x81 -> `data_valid` with 0x81.
- Default N=650, send 0x55 -> `data_valid` at T0+2+325+5850 = T0+6177, `data_out` = 0x55.
